serial_xfer_ctrl: RTL and testbench
===================================

// Module: serial_xfer_ctrl
// PURPOSE
//  SPI-style (mode 0) serial transfer controller; one full-duplex WIDTH-bit word per request.
//  Sequences a piso_reg (tx shift), a sipo_reg (rx capture) and a limit_counter (bit count).
//  Generates sclk/cs_n; sits between logger capture logic and an external ADC/flash device.
// PARAMETERS
//  WIDTH  8  bits per transfer, MSB first; legal >= 2
//  DIV    4  clk cycles per sclk half-period; legal >= 1 (DIV=1 -> sclk = clk/2)
// PORTS
//  clk          in   1      system clock; all state updates on posedge
//  clr          in   1      reset: synchronous, active-high; aborts any transfer
//  start_valid  in   1      request a transfer of tx_data
//  start_ready  out  1      controller idle; request accepted on the clk edge where valid&ready
//  tx_data      in   WIDTH  word to send; sampled only on the accepting edge
//  rx_data      out  WIDTH  last received word; stable from rx_valid until next accept
//  rx_valid     out  1      one-cycle pulse: rx_data holds a completed word
//  busy         out  1      ~start_ready
//  sclk         out  1      serial clock, idles low
//  cs_n         out  1      chip select, active low
//  mosi         out  1      serial out = piso MSB
//  miso         in   1      serial in; sampled on rising sclk
// BEHAVIOUR
//  Reset: state IDLE, start_ready=1, busy=0, sclk=0, cs_n=1, mosi=0, rx_valid=0, rx_data=0.
//  All outputs registered or decoded from registered state; no comb path input->output.
//  States: IDLE -> SETUP -> XFER -> HOLD -> IDLE. Accepting edge = E0.
//   IDLE : start_ready=1, cs_n=1. On valid&ready: load piso<=tx_data, clear sipo, bit cnt, div cnt.
//   SETUP: cs_n=0, sclk=0, mosi=tx_data[WIDTH-1]; DIV cycles (leave at edge E_DIV).
//   XFER : div cnt counts 0..DIV-1; at terminal count sclk toggles, div cnt wraps to 0.
//          Rising toggle (sclk 0->1): sipo shifts in miso (value present at that clk edge).
//          Falling toggle (sclk 1->0): piso shifts left, bit cnt increments.
//          Falling toggle with bit cnt == WIDTH-1 -> HOLD. Duration exactly 2*DIV*WIDTH cycles.
//   HOLD : cs_n=0, sclk=0; DIV cycles; then IDLE.
//  On edge E_((2*WIDTH+2)*DIV): state=IDLE, cs_n=1, rx_data<=sipo, rx_valid=1 for one cycle.
//   WIDTH=8, DIV=4 -> rx_valid high in the cycle after edge E72.
//  Exactly WIDTH rising sclk edges per transfer; sclk never high outside XFER.
//  start_valid while busy: ignored (not queued); tx_data ignored.
//  Back-to-back: start_ready=1 in the rx_valid cycle; accept there -> cs_n high that one cycle, SETUP next.
//  clr mid-transfer: next edge all outputs to reset values; no rx_valid; rx_data=0; start_ready=1.
//  clr and start_valid same edge: clr wins, request not accepted.
//  Counters sized $clog2(WIDTH), $clog2(DIV) (min 1 bit); no overflow by construction.
// STRUCTURE
//  Package serial_xfer_pkg: typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} xfer_state_t.
//  Datapath reuses library piso_reg, sipo_reg, limit_counter (bit cnt, limit WIDTH-1).
//  One new sub-module: sclk_gen (div counter + sclk toggle; emits rise/fall strobes).
//  FSM + output registers in serial_xfer_ctrl top.
// TESTING (WIDTH=8, DIV=4 unless stated)
//  1 Hold clr 3 cycles -> sclk=0, cs_n=1, rx_valid=0, rx_data=0, start_ready=1.
//  2 tx 0xA5, miso=mosi loopback -> mosi 1,0,1,0,0,1,0,1; 8 sclk rises; rx_data=0xA5, rx_valid after E72.
//  3 tx 0x00, miso tied 1 -> mosi constant 0; rx_data=0xFF; cs_n low for exactly 72 cycles.
//  4 start_valid held high 200 cycles, tx 0x12 then 0x34 -> 2nd accepted in rx_valid cycle; rx 0x12, 0x34.
//  5 clr at cycle 20 of transfer -> next cycle sclk=0, cs_n=1; no rx_valid ever; new request accepted.
//  6 DIV=1, tx 0x3C loopback -> sclk period 2 clk; rx_data=0x3C, rx_valid after E18.

Source files
------------

// File: rtl/serial_xfer_pkg.sv
// Shared types and helpers for the serial transfer controller.
package serial_xfer_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} xfer_state_t;

  // Counter width for a modulus n, never below one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/limit_counter.sv
// Up counter that wraps to zero after LIMIT; flags when it sits at LIMIT.
module limit_counter
  import serial_xfer_pkg::*;
#(
  parameter int LIMIT = 7
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic at_limit
);

  localparam int CW = cnt_bits(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || clear) cnt <= '0;
    else if (en)      cnt <= (cnt == LIM) ? '0 : cnt + 1'b1;
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
module piso_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/sclk_gen.sv
// Divider for the serial clock: DIV clk cycles per half-period, with edge strobes.
module sclk_gen
  import serial_xfer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic run,
  input  logic toggle_en,
  output logic sclk,
  output logic tc,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_bits(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Strobes fire in the cycle before the edge on which sclk actually changes.
  assign tc   = run && (cnt == LAST);
  assign rise = tc && toggle_en && !sclk;
  assign fall = tc && toggle_en && sclk;

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (run)       cnt  <= tc ? '0 : cnt + 1'b1;
      if (rise)      sclk <= 1'b1;
      else if (fall) sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_reg.sv
// Serial-in parallel-out shift register, new bit enters at the LSB.
module sipo_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr || clear) q <= '0;
    else if (shift)   q <= {q[WIDTH-2:0], sin};
  end

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Mode-0 full-duplex serial transfer controller: one WIDTH-bit word per accepted request.
module serial_xfer_ctrl
  import serial_xfer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  xfer_state_t      state, state_n;
  logic             accept, done;
  logic             tc, rise, fall, bit_last;
  logic [WIDTH-1:0] sipo_q;

  assign accept = start_valid && (state == IDLE);

  piso_reg #(.WIDTH(WIDTH)) u_piso (
    .clk(clk), .clr(clr), .load(accept), .shift(fall), .din(tx_data), .sout(mosi)
  );

  sipo_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk(clk), .clr(clr), .clear(accept), .shift(rise), .sin(miso), .q(sipo_q)
  );

  limit_counter #(.LIMIT(WIDTH - 1)) u_bit_cnt (
    .clk(clk), .clr(clr), .clear(accept), .en(fall), .at_limit(bit_last)
  );

  sclk_gen #(.DIV(DIV)) u_sclk (
    .clk(clk), .clr(clr), .clear(accept), .run(state != IDLE),
    .toggle_en(state == XFER), .sclk(sclk), .tc(tc), .rise(rise), .fall(fall)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_n = SETUP;
      SETUP: if (tc) state_n = XFER;
      XFER:  if (fall && bit_last) state_n = HOLD;
      HOLD:  if (tc) begin
               state_n = IDLE;
               done    = 1'b1;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_n;
      rx_valid <= done;
      if (done) rx_data <= sipo_q;
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = ~start_ready;
  assign cs_n        = (state == IDLE);

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Scoreboard bench: a DIV=4 and a DIV=1 instance, directed transfers, monitor-side checking.
module tb_serial_xfer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance A: WIDTH=8, DIV=4
  logic       clr_a, sv_a, sr_a, busy_a, sclk_a, csn_a, mosi_a, rxv_a, miso_a, loop_a, mfix_a;
  logic [7:0] tx_a, rx_a;
  assign miso_a = loop_a ? mosi_a : mfix_a;

  serial_xfer_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
    .clk(clk), .clr(clr_a), .start_valid(sv_a), .start_ready(sr_a), .tx_data(tx_a),
    .rx_data(rx_a), .rx_valid(rxv_a), .busy(busy_a), .sclk(sclk_a), .cs_n(csn_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  // Instance B: WIDTH=8, DIV=1
  logic       clr_b, sv_b, sr_b, busy_b, sclk_b, csn_b, mosi_b, rxv_b, miso_b;
  logic [7:0] tx_b, rx_b;
  assign miso_b = mosi_b;

  serial_xfer_ctrl #(.WIDTH(8), .DIV(1)) dut_b (
    .clk(clk), .clr(clr_b), .start_valid(sv_b), .start_ready(sr_b), .tx_data(tx_b),
    .rx_data(rx_b), .rx_valid(rxv_b), .busy(busy_b), .sclk(sclk_b), .cs_n(csn_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  // Monitor-owned observation state.
  int         acc_a = 0, acc_b = 0;
  int         rises_a = 0, rises_b = 0, csn_low_a = 0, csn_low_b = 0, last_rise_b = 0;
  logic       prev_sclk_a = 1'b0, prev_sclk_b = 1'b0;
  logic [7:0] mosi_hist_a = '0, mosi_hist_b = '0;

  initial begin : monitor
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rxv_a) begin
        check("rx_expected_a", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          exp = q_a.pop_front();
          check("rx_data_a", rx_a, exp);
          check("rx_latency_a", cyc - acc_a, 72);
        end
      end
      if (sv_a && sr_a && !clr_a) acc_a = cyc + 1;
      if (sclk_a && !prev_sclk_a) begin
        rises_a++;
        mosi_hist_a = {mosi_hist_a[6:0], mosi_a};
      end
      if (!csn_a) csn_low_a++;
      if (csn_a) check("sclk_low_deselected_a", sclk_a, 0);
      prev_sclk_a = sclk_a;

      if (rxv_b) begin
        check("rx_expected_b", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          exp = q_b.pop_front();
          check("rx_data_b", rx_b, exp);
          check("rx_latency_b", cyc - acc_b, 18);
        end
      end
      if (sv_b && sr_b && !clr_b) acc_b = cyc + 1;
      if (sclk_b && !prev_sclk_b) begin
        if (rises_b > 0) check("sclk_period_b", cyc - last_rise_b, 2);
        rises_b++;
        last_rise_b = cyc;
        mosi_hist_b = {mosi_hist_b[6:0], mosi_b};
      end
      if (!csn_b) csn_low_b++;
      if (csn_b) check("sclk_low_deselected_b", sclk_b, 0);
      prev_sclk_b = sclk_b;
    end
  end

  task automatic wait_rx(input int which, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 0) ? rxv_a : rxv_b) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // Single transfer with per-transfer checks of sclk rises, mosi bits and cs_n low time.
  task automatic xfer(input int which, input logic [7:0] d, input logic [7:0] exp_rx,
                      input int exp_csn_low);
    int r0, c0;
    @(posedge clk); #1;
    r0 = (which == 0) ? rises_a : rises_b;
    c0 = (which == 0) ? csn_low_a : csn_low_b;
    if (which == 0) begin q_a.push_back(exp_rx); tx_a = d; sv_a = 1'b1; end
    else            begin q_b.push_back(exp_rx); tx_b = d; sv_b = 1'b1; end
    @(posedge clk); #1;
    sv_a = 1'b0;
    sv_b = 1'b0;
    wait_rx(which, "rx_timeout");
    check("sclk_rises", ((which == 0) ? rises_a : rises_b) - r0, 8);
    check("csn_low_cycles", ((which == 0) ? csn_low_a : csn_low_b) - c0, exp_csn_low);
    check("mosi_bits", (which == 0) ? mosi_hist_a : mosi_hist_b, d);
    @(negedge clk);
    check("rx_valid_pulse", (which == 0) ? rxv_a : rxv_b, 0);
  endtask

  initial begin : driver
    clr_a = 1'b1; sv_a = 1'b0; tx_a = '0; loop_a = 1'b1; mfix_a = 1'b0;
    clr_b = 1'b1; sv_b = 1'b0; tx_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sclk", sclk_a, 0);
    check("reset_cs_n", csn_a, 1);
    check("reset_rx_valid", rxv_a, 0);
    check("reset_rx_data", rx_a, 8'h00);
    check("reset_start_ready", sr_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_mosi", mosi_a, 0);
    @(posedge clk); #1;
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Loopback 0xA5
    loop_a = 1'b1;
    xfer(0, 8'hA5, 8'hA5, 72);

    // 0x00 out, miso tied high
    loop_a = 1'b0; mfix_a = 1'b1;
    xfer(0, 8'h00, 8'hFF, 72);

    // start_valid held through a transfer: second request taken in the rx_valid cycle
    loop_a = 1'b1;
    q_a.push_back(8'h12);
    q_a.push_back(8'h34);
    @(posedge clk); #1;
    tx_a = 8'h12; sv_a = 1'b1;
    @(posedge clk); #1;
    tx_a = 8'h34;
    wait_rx(0, "rx_timeout_b2b_first");
    check("b2b_ready_in_rx_cycle", sr_a, 1);
    check("b2b_cs_n_high_in_rx_cycle", csn_a, 1);
    @(posedge clk); #1;
    check("b2b_second_accepted", busy_a, 1);
    check("b2b_second_cs_n", csn_a, 0);
    sv_a = 1'b0;
    wait_rx(0, "rx_timeout_b2b_second");

    // Abort mid-transfer while sclk is high
    @(posedge clk); #1;
    tx_a = 8'hC3; sv_a = 1'b1;
    @(posedge clk); #1;
    sv_a = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("abort_sclk_high_before", sclk_a, 1);
    #1 clr_a = 1'b1;
    @(negedge clk);
    check("abort_sclk", sclk_a, 0);
    check("abort_cs_n", csn_a, 1);
    check("abort_start_ready", sr_a, 1);
    check("abort_rx_data", rx_a, 8'h00);
    check("abort_mosi", mosi_a, 0);
    check("abort_rx_valid", rxv_a, 0);
    @(posedge clk); #1;
    clr_a = 1'b0;

    // clr and start_valid together: clr wins
    @(posedge clk); #1;
    clr_a = 1'b1; sv_a = 1'b1; tx_a = 8'hFF;
    @(posedge clk); #1;
    clr_a = 1'b0; sv_a = 1'b0;
    @(negedge clk);
    check("clr_beats_start_ready", sr_a, 1);
    check("clr_beats_start_cs_n", csn_a, 1);
    repeat (100) @(posedge clk);

    // New request after abort
    xfer(0, 8'h5A, 8'h5A, 72);

    // DIV=1 instance, loopback 0x3C
    xfer(1, 8'h3C, 8'h3C, 18);

    repeat (5) @(posedge clk);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
